// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF challenge sequencer:
// FSM state encoding, challenge/LFSR geometry and small LFSR helpers.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLEAR   = 3'd2,
    RUN     = 3'd3,
    HOLD    = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } puf_state_e;

  localparam int CHAL_W = 5;
  localparam int LFSR_W = 10;

  // Feedback taps of x^10 + x^7 + 1 in a left-shifting Fibonacci register.
  localparam int LFSR_TAP_HI = 9;
  localparam int LFSR_TAP_LO = 6;

  // The all-zero state is a lock-up state, so a zero seed is replaced.
  localparam logic [LFSR_W-1:0] LFSR_SEED_SUB = 10'h001;

  // Replace the lock-up seed by the substitute value.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    if (s == {LFSR_W{1'b0}}) begin
      r = LFSR_SEED_SUB;
    end else begin
      r = s;
    end
    return r;
  endfunction

  // One LFSR step: shift left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

  // Slice B challenge: upper half of the state, forced distinct from slice A.
  function automatic logic [CHAL_W-1:0] chal_b_of(input logic [LFSR_W-1:0] s);
    logic [CHAL_W-1:0] r;
    if (s[LFSR_W-1:CHAL_W] == s[CHAL_W-1:0]) begin
      r = s[CHAL_W-1:0] ^ 5'h01;
    end else begin
      r = s[LFSR_W-1:CHAL_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/puf_lfsr10.sv
// 10-bit challenge LFSR with synchronous load (seed) and step controls.
module puf_lfsr10
  import puf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] lfsr_r;

  // LFSR register: load takes priority over step; zero seed is substituted.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      lfsr_r <= LFSR_SEED_SUB;
    end else if (load) begin
      lfsr_r <= seed_fix(load_val);
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign state = lfsr_r;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF initiator: for each response bit it issues a challenge
// pair, clears both counter slices, runs one timed oscillation window, waits
// for the counts to settle and turns the count comparison into one bit.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int N_BITS = 16,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        seed,
  output logic [4:0]        chal_a,
  output logic [4:0]        chal_b,
  output logic              osc_en,
  output logic              cnt_clr,
  input  logic [CNT_W-1:0]  count_a,
  input  logic [CNT_W-1:0]  count_b,
  output logic              busy,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] resp_data,
  output logic [5:0]        tie_cnt
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  puf_state_e        state_r, state_s;
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic [N_BITS-1:0] resp_r, resp_s;
  logic [5:0]        tie_r, tie_s;
  logic [CHAL_W-1:0] chal_a_r, chal_a_s;
  logic [CHAL_W-1:0] chal_b_r, chal_b_s;
  logic              osc_en_r, cnt_clr_r, busy_r, resp_valid_r;

  logic              lfsr_load_s;
  logic              lfsr_step_s;
  logic [LFSR_W-1:0] lfsr_state_s;
  logic [LFSR_W-1:0] chal_src_s;

  puf_lfsr10 u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load_s),
    .load_val (seed),
    .step     (lfsr_step_s),
    .state    (lfsr_state_s)
  );

  // The first challenge comes straight from the (fixed-up) seed so that it is
  // already on the outputs during LOAD; later ones come from the stepped LFSR.
  assign chal_src_s = (state_r == IDLE) ? seed_fix(seed) : lfsr_state_s;

  // Next-state, datapath and LFSR control decode.
  always_comb begin
    state_s     = state_r;
    tmr_s       = tmr_r;
    idx_s       = idx_r;
    resp_s      = resp_r;
    tie_s       = tie_r;
    chal_a_s    = chal_a_r;
    chal_b_s    = chal_b_r;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          lfsr_load_s = 1'b1;
          idx_s       = {IDX_W{1'b0}};
          resp_s      = {N_BITS{1'b0}};
          tie_s       = 6'd0;
          chal_a_s    = chal_src_s[CHAL_W-1:0];
          chal_b_s    = chal_b_of(chal_src_s);
          state_s     = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        lfsr_step_s = 1'b1;
        state_s     = CLEAR;
      end
      CLEAR: begin
        tmr_s   = TMR_W'(WINDOW - 1);
        state_s = RUN;
      end
      RUN: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          tmr_s   = TMR_W'(SETTLE - 1);
          state_s = HOLD;
        end else begin
          tmr_s = tmr_r - TMR_W'(1);
        end
      end
      HOLD: begin
        if (tmr_r == {TMR_W{1'b0}}) begin
          state_s = COMPARE;
        end else begin
          tmr_s = tmr_r - TMR_W'(1);
        end
      end
      COMPARE: begin
        resp_s[idx_r] = (count_a > count_b);
        if (count_a == count_b) begin
          if (tie_r != 6'd63) begin
            tie_s = tie_r + 6'd1;
          end else begin
            tie_s = tie_r;
          end
        end else begin
          tie_s = tie_r;
        end
        idx_s = idx_r + IDX_W'(1);
        if (idx_r == IDX_W'(N_BITS - 1)) begin
          state_s = DONE;
        end else begin
          chal_a_s = chal_src_s[CHAL_W-1:0];
          chal_b_s = chal_b_of(chal_src_s);
          state_s  = LOAD;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r  <= IDLE;
      tmr_r    <= {TMR_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      resp_r   <= {N_BITS{1'b0}};
      tie_r    <= 6'd0;
      chal_a_r <= {CHAL_W{1'b0}};
      chal_b_r <= {CHAL_W{1'b0}};
    end else begin
      state_r  <= state_s;
      tmr_r    <= tmr_s;
      idx_r    <= idx_s;
      resp_r   <= resp_s;
      tie_r    <= tie_s;
      chal_a_r <= chal_a_s;
      chal_b_r <= chal_b_s;
    end
  end

  // Registered control outputs, decoded from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      osc_en_r     <= 1'b0;
      cnt_clr_r    <= 1'b0;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      osc_en_r     <= (state_s == RUN);
      cnt_clr_r    <= (state_s == CLEAR);
      busy_r       <= (state_s != IDLE);
      resp_valid_r <= (state_s == DONE);
    end
  end

  assign chal_a     = chal_a_r;
  assign chal_b     = chal_b_r;
  assign osc_en     = osc_en_r;
  assign cnt_clr    = cnt_clr_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_r;
  assign tie_cnt    = tie_r;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench: each request pushes its expected challenge pairs and
// response into queues; a monitor pops and compares as the DUT presents them.
module tb_puf_challenge_sequencer;

  localparam int N_BITS  = 4;
  localparam int CNT_W   = 16;
  localparam int WINDOW  = 8;
  localparam int SETTLE  = 2;
  localparam int BIT_CYC = WINDOW + SETTLE + 3;
  localparam int LAT     = N_BITS * BIT_CYC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [9:0]        seed = 10'd0;
  logic              resp_ready = 1'b0;
  logic [4:0]        chal_a, chal_b;
  logic              osc_en, cnt_clr, busy, resp_valid;
  logic [CNT_W-1:0]  count_a, count_b;
  logic [N_BITS-1:0] resp_data;
  logic [5:0]        tie_cnt;

  typedef struct packed {
    logic [N_BITS-1:0] data;
    logic [5:0]        ties;
    logic [31:0]       t0;
  } resp_t;

  resp_t      resp_q[$];
  logic [9:0] chal_q[$];

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int          mode = 0;   // 0: oscillator table, 1: A = B + 5, 2: A = B
  logic [CNT_W-1:0] freq [32];

  puf_challenge_sequencer #(
    .N_BITS(N_BITS), .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .chal_a(chal_a), .chal_b(chal_b), .osc_en(osc_en), .cnt_clr(cnt_clr),
    .count_a(count_a), .count_b(count_b), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .tie_cnt(tie_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator bank model: each select maps to a fixed count.
  always_comb begin
    count_b = freq[chal_b];
    if (mode == 1)      count_a = freq[chal_b] + 16'd5;
    else if (mode == 2) count_a = freq[chal_b];
    else                count_a = freq[chal_a];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: walks the challenge LFSR arithmetically and decides bits.
  task automatic push_model(input logic [9:0] sd, input int unsigned t0);
    logic [9:0] l;
    logic [4:0] lo, hi, cb;
    logic       fb;
    resp_t      r;
    int         ties;
    ties   = 0;
    r.data = '0;
    l      = (sd == 10'd0) ? 10'h001 : sd;
    for (int i = 0; i < N_BITS; i++) begin
      lo = l % 32;
      hi = l / 32;
      cb = (hi == lo) ? (lo ^ 5'h01) : hi;
      chal_q.push_back({lo, cb});
      if (mode == 1) r.data[i] = 1'b1;
      else if (mode == 2) ties++;
      else if (freq[lo] > freq[cb]) r.data[i] = 1'b1;
      else if (freq[lo] == freq[cb]) ties++;
      fb = l[9] ^ l[6];
      l  = 10'((l * 2) % 1024 + {9'd0, fb});
    end
    r.ties = (ties > 63) ? 6'd63 : 6'(ties);
    r.t0   = t0;
    resp_q.push_back(r);
  endtask

  // Monitor: challenge pairs at every counter clear, window length, response.
  initial begin
    logic       prev_valid, prev_osc, prev_clr;
    int         osc_len;
    logic [9:0] ec;
    resp_t      r, held;
    prev_valid = 1'b0; prev_osc = 1'b0; prev_clr = 1'b0; osc_len = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        prev_valid = 1'b0; prev_osc = 1'b0; prev_clr = 1'b0; osc_len = 0;
      end else begin
        if (cnt_clr) begin
          if (chal_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL chal_unexpected: got %0h, expected none", {chal_a, chal_b});
          end else begin
            ec = chal_q.pop_front();
            chk("chal_pair", 32'({chal_a, chal_b}), 32'(ec));
          end
        end
        if (osc_en) begin
          if (!prev_osc) chk("clr_before_osc", 32'(prev_clr), 32'd1);
          osc_len++;
        end else if (prev_osc) begin
          chk("window_len", 32'(osc_len), 32'(WINDOW));
          osc_len = 0;
        end
        if (resp_valid && !prev_valid) begin
          if (resp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL resp_unexpected: got %0h, expected none", resp_data);
          end else begin
            r = resp_q.pop_front();
            chk("resp_data", 32'(resp_data), 32'(r.data));
            chk("tie_cnt", 32'(tie_cnt), 32'(r.ties));
            chk("latency", cyc - r.t0, 32'(LAT));
            chk("busy_in_done", 32'(busy), 32'd1);
            held = r;
          end
        end else if (resp_valid) begin
          chk("resp_stable", 32'({tie_cnt, resp_data}), 32'({held.ties, held.data}));
        end
        prev_valid = resp_valid;
        prev_osc   = osc_en;
        prev_clr   = cnt_clr;
      end
    end
  end

  // One full request: start, wait for response, optional back-pressure.
  task automatic run_req(input logic [9:0] sd, input int md, input int hold, input bit poke);
    int waited;
    mode  = md;
    seed  = sd;
    start = 1'b1;
    push_model(sd, cyc + 1);
    @(negedge clk);
    start  = 1'b0;
    seed   = 10'($urandom);
    waited = 0;
    while (!resp_valid && waited < LAT + 20) begin
      @(negedge clk);
      waited++;
    end
    if (!resp_valid) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: got no resp_valid, expected it within %0d cycles", LAT + 20);
      resp_q.delete();
      chal_q.delete();
      return;
    end
    for (int i = 0; i < hold; i++) begin
      start = (poke && (i % 10 == 5)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    start      = poke;   // start during the handshake must be ignored
    @(negedge clk);
    resp_ready = 1'b0;
    start      = 1'b0;
    chk("busy_after_hs", 32'(busy), 32'd0);
    chk("valid_after_hs", 32'(resp_valid), 32'd0);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // Stimulus sequence.
  initial begin
    logic [9:0] sd;
    int waited;
    for (int i = 0; i < 32; i++) freq[i] = 16'(1000 + $urandom_range(0, 15));

    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({chal_a, chal_b, osc_en, cnt_clr, busy, resp_valid, resp_data, tie_cnt}), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    run_req(10'h000, 0, 0, 1'b0);   // zero seed: first pair 1 / 0
    run_req(10'h021, 1, 0, 1'b0);   // equal halves: forced distinct, all ones
    run_req(10'($urandom), 2, 0, 1'b0);   // all ties
    sd = 10'($urandom);
    run_req(sd, 0, 50, 1'b1);       // back-pressure, ignored start pulses
    run_req(sd, 0, 0, 1'b0);        // same seed again: same sequence

    // Reset while the oscillators are running, well into a request.
    mode  = 0;
    sd    = 10'($urandom);
    seed  = sd;
    start = 1'b1;
    push_model(sd, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (3 * BIT_CYC) @(negedge clk);
    waited = 0;
    while (!osc_en && waited < 2 * BIT_CYC) begin
      @(negedge clk);
      waited++;
    end
    chk("reached_run", 32'(osc_en), 32'd1);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_osc_en", 32'(osc_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    resp_q.delete();
    chal_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    run_req(sd, 0, 0, 1'b0);        // clean run after reset

    for (int k = 0; k < 6; k++) begin
      run_req(10'($urandom), $urandom_range(0, 2), $urandom_range(0, 5),
              1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("chal_q_drained", 32'(chal_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
